// File: rtl/regfile_pc_param_pkg.sv
// Shared definitions for the regfile_pc_param register file.
//   - Default widths and PC increment used by the top-level parameters.
//   - pc_src_e: which source updates the program counter this cycle.
//   - pc_select(): fixed-priority choice of that source.
package regfile_pc_param_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_NRD    = 3;
  localparam int DEF_PC_INC = 4;

  typedef enum logic [1:0] {
    PC_SRC_HOLD,
    PC_SRC_LOAD,
    PC_SRC_GPR,
    PC_SRC_INC
  } pc_src_e;

  // External load beats a GPR write to the PC index, which beats auto-increment.
  function automatic pc_src_e pc_select(input logic pc_ld,
                                        input logic gpr_pc_hit,
                                        input logic pc_en);
    if (pc_ld)           return PC_SRC_LOAD;
    else if (gpr_pc_hit) return PC_SRC_GPR;
    else if (pc_en)      return PC_SRC_INC;
    else                 return PC_SRC_HOLD;
  endfunction

endpackage

// File: rtl/rf_word_reg.sv
// One general-purpose register word: W-bit D flop with load enable.
// Ports:
//   clk  rising-edge clock
//   clr  asynchronous, active-low clear (word goes to 0)
//   en   load enable
//   d    next value, captured when en is high
//   q    current value
module rf_word_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // NOTE: every storage word is flop-based and gets the async clear, because
  // the register file must read back as all zeros straight out of reset; a
  // RAM macro without reset could not honour that.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      q <= '0;
    end else if (en) begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples its inputs from before the edge, independent of block order.
      q <= d;
    end
  end

endmodule

// File: rtl/regfile_pc_param.sv
// Decode-stage register file: 2**ADDR_W words of DATA_W bits, NRD combinational
// read ports, one write port. The top index holds the program counter, which
// auto-increments and can be loaded externally or through the write port.
// Ports:
//   clk, clr   rising-edge clock, asynchronous active-low clear
//   we/waddr/wdata   GPR write port (a write to the top index targets the PC)
//   raddr      NRD packed read indices, port k = raddr[k*ADDR_W +: ADDR_W]
//   rdata      NRD packed read words,   port k = rdata[k*DATA_W +: DATA_W]
//   pc_en      PC auto-increment enable (+PC_INC, wraps)
//   pc_ld      external PC load of pc_in (branch target)
//   pc_out     current PC
//   pc_clash   registered: pc_ld and a write to the PC index in the same cycle
// BYPASS=1 forwards wdata to matching read ports in the write cycle (never for
// the PC). ZERO_R0=1 makes register 0 a constant zero.
module regfile_pc_param
  import regfile_pc_param_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int NRD     = DEF_NRD,
  parameter int PC_INC  = DEF_PC_INC,
  parameter bit BYPASS  = 1'b1,
  parameter bit ZERO_R0 = 1'b0
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [NRD*ADDR_W-1:0] raddr,
  output logic [NRD*DATA_W-1:0] rdata,
  input  logic                  pc_en,
  input  logic                  pc_ld,
  input  logic [DATA_W-1:0]     pc_in,
  output logic [DATA_W-1:0]     pc_out,
  output logic                  pc_clash
);

  localparam int                NREGS  = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PC_IDX = ADDR_W'(NREGS - 1);

  logic [NREGS-1:0][DATA_W-1:0] regs;
  logic                         gpr_pc_hit;
  logic [DATA_W-1:0]            pc_q;
  logic [DATA_W-1:0]            pc_d;
  pc_src_e                      pc_src;

  assign gpr_pc_hit = we && (waddr == PC_IDX);

  // General-purpose words 0 .. NREGS-2; the top slot is the PC below.
  for (genvar i = 0; i < NREGS - 1; i++) begin : g_gpr
    if (ZERO_R0 && (i == 0)) begin : g_zero
      assign regs[i] = '0;
    end else begin : g_word
      rf_word_reg #(.W(DATA_W)) u_word (
        .clk (clk),
        .clr (clr),
        .en  (we && (waddr == ADDR_W'(i))),
        .d   (wdata),
        .q   (regs[i])
      );
    end
  end

  always_comb begin
    pc_src = pc_select(pc_ld, gpr_pc_hit, pc_en);
    // NOTE: pc_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    pc_d   = pc_q;
    unique case (pc_src)
      PC_SRC_LOAD: pc_d = pc_in;
      PC_SRC_GPR:  pc_d = wdata;
      PC_SRC_INC:  pc_d = pc_q + DATA_W'(PC_INC);
      PC_SRC_HOLD: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      pc_q     <= '0;
      pc_clash <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      pc_clash <= pc_ld && gpr_pc_hit;
    end
  end

  assign regs[NREGS-1] = pc_q;
  assign pc_out        = pc_q;

  // Read ports: plain indexed read plus optional same-cycle forwarding. The PC
  // is excluded from forwarding so fetch always sees the pre-update value.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              byp_hit;

    assign ra      = raddr[k*ADDR_W +: ADDR_W];
    assign byp_hit = BYPASS && we && (ra == waddr) && (ra != PC_IDX)
                     && !(ZERO_R0 && (ra == '0));
    assign rdata[k*DATA_W +: DATA_W] = byp_hit ? wdata : regs[ra];
  end

endmodule

// File: tb/tb_regfile_pc_param.sv
// Directed bench for regfile_pc_param. Three instances share the stimulus:
//   u_byp   BYPASS=1, ZERO_R0=0
//   u_nobyp BYPASS=0, ZERO_R0=0
//   u_zero  BYPASS=1, ZERO_R0=1
// Inputs change 1 time unit after a rising edge; outputs are sampled between edges.
module tb_regfile_pc_param;

  logic        clk;
  logic        clr;
  logic        we;
  logic [3:0]  waddr;
  logic [31:0] wdata;
  logic [11:0] raddr;
  logic        pc_en;
  logic        pc_ld;
  logic [31:0] pc_in;

  logic [95:0] rdata_b, rdata_n, rdata_z;
  logic [31:0] pc_b, pc_n, pc_z;
  logic        clash_b, clash_n, clash_z;

  int tests;
  int fails;

  regfile_pc_param #(.BYPASS(1'b1), .ZERO_R0(1'b0)) u_byp (
    .clk(clk), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
    .rdata(rdata_b), .pc_en(pc_en), .pc_ld(pc_ld), .pc_in(pc_in),
    .pc_out(pc_b), .pc_clash(clash_b)
  );

  regfile_pc_param #(.BYPASS(1'b0), .ZERO_R0(1'b0)) u_nobyp (
    .clk(clk), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
    .rdata(rdata_n), .pc_en(pc_en), .pc_ld(pc_ld), .pc_in(pc_in),
    .pc_out(pc_n), .pc_clash(clash_n)
  );

  regfile_pc_param #(.BYPASS(1'b1), .ZERO_R0(1'b1)) u_zero (
    .clk(clk), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
    .rdata(rdata_z), .pc_en(pc_en), .pc_ld(pc_ld), .pc_in(pc_in),
    .pc_out(pc_z), .pc_clash(clash_z)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b0; we = 1'b1; waddr = 4'd3; wdata = 32'hAA; pc_en = 1'b1;
    pc_ld = 1'b0; pc_in = '0; raddr = {4'd15, 4'd2, 4'd1};
    #3;
    tests++;
    if (rdata_b !== 96'h0 || rdata_n !== 96'h0 || rdata_z !== 96'h0) begin
      fails++; $display("FAIL reset_rdata: got %h/%h/%h want 0", rdata_b, rdata_n, rdata_z);
    end
    tests++;
    if (pc_b !== 32'h0 || clash_b !== 1'b0) begin
      fails++; $display("FAIL reset_pc: got pc=%h clash=%b want 0/0", pc_b, clash_b);
    end
    step();
    tests++;
    if (pc_b !== 32'h0 || rdata_b !== 96'h0) begin
      fails++; $display("FAIL reset_held_edge: got pc=%h rdata=%h want 0", pc_b, rdata_b);
    end
    we = 1'b0;
    clr = 1'b1;
    step();
    tests++;
    if (pc_b !== 32'h4 || pc_n !== 32'h4 || pc_z !== 32'h4) begin
      fails++; $display("FAIL reset_release_pc: got %h/%h/%h want 4", pc_b, pc_n, pc_z);
    end
  endtask

  task automatic test_write_read();
    pc_en = 1'b0;
    we = 1'b1; waddr = 4'd5; wdata = 32'hDEAD_BEEF; raddr = {4'd5, 4'd5, 4'd5};
    #1;
    tests++;
    if (rdata_b !== {3{32'hDEAD_BEEF}}) begin
      fails++; $display("FAIL bypass_same_cycle: got %h want %h", rdata_b, {3{32'hDEAD_BEEF}});
    end
    tests++;
    if (rdata_n !== 96'h0) begin
      fails++; $display("FAIL nobypass_before_edge: got %h want 0", rdata_n);
    end
    step();
    we = 1'b0;
    #1;
    tests++;
    if (rdata_b !== {3{32'hDEAD_BEEF}} || rdata_n !== {3{32'hDEAD_BEEF}}) begin
      fails++; $display("FAIL write_after_edge: got %h/%h want %h", rdata_b, rdata_n, {3{32'hDEAD_BEEF}});
    end
    raddr = {4'd15, 4'd5, 4'd0};
    #1;
    tests++;
    if (rdata_b !== {32'h4, 32'hDEAD_BEEF, 32'h0}) begin
      fails++; $display("FAIL mixed_ports: got %h want %h", rdata_b, {32'h4, 32'hDEAD_BEEF, 32'h0});
    end
  endtask

  task automatic test_pc_count();
    pc_ld = 1'b1; pc_in = 32'h0;
    step();
    pc_ld = 1'b0; pc_en = 1'b1;
    tests++;
    if (pc_b !== 32'h0) begin
      fails++; $display("FAIL pc_load_zero: got %h want 0", pc_b);
    end
    for (int i = 1; i <= 3; i++) begin
      step();
      tests++;
      if (pc_b !== 32'(4 * i)) begin
        fails++; $display("FAIL pc_count_%0d: got %h want %h", i, pc_b, 32'(4 * i));
      end
    end
    pc_en = 1'b0;
    pc_ld = 1'b1; pc_in = 32'hFFFF_FFFC;
    step();
    pc_ld = 1'b0; pc_en = 1'b1;
    tests++;
    if (pc_b !== 32'hFFFF_FFFC) begin
      fails++; $display("FAIL pc_preset: got %h want fffffffc", pc_b);
    end
    step();
    pc_en = 1'b0;
    tests++;
    if (pc_b !== 32'h0) begin
      fails++; $display("FAIL pc_wrap: got %h want 0", pc_b);
    end
  endtask

  task automatic test_priority();
    pc_ld = 1'b1; pc_in = 32'h100; we = 1'b1; waddr = 4'd15; wdata = 32'h200;
    pc_en = 1'b1; raddr = {4'd15, 4'd15, 4'd15};
    #1;
    tests++;
    if (rdata_b !== 96'h0) begin
      fails++; $display("FAIL pc_read_not_bypassed: got %h want 0", rdata_b);
    end
    step();
    tests++;
    if (pc_b !== 32'h100 || clash_b !== 1'b1 || clash_n !== 1'b1) begin
      fails++; $display("FAIL prio_load: got pc=%h clash=%b/%b want 100/1/1", pc_b, clash_b, clash_n);
    end
    pc_ld = 1'b0;
    step();
    tests++;
    if (pc_b !== 32'h200 || clash_b !== 1'b0) begin
      fails++; $display("FAIL prio_gpr: got pc=%h clash=%b want 200/0", pc_b, clash_b);
    end
    we = 1'b0;
    step();
    pc_en = 1'b0;
    tests++;
    if (pc_b !== 32'h204 || clash_b !== 1'b0) begin
      fails++; $display("FAIL prio_inc: got pc=%h clash=%b want 204/0", pc_b, clash_b);
    end
  endtask

  task automatic test_zero_r0();
    we = 1'b1; waddr = 4'd1; wdata = 32'h55;
    step();
    waddr = 4'd0; wdata = 32'h1234; raddr = {4'd1, 4'd0, 4'd0};
    #1;
    tests++;
    if (rdata_z !== {32'h55, 32'h0, 32'h0}) begin
      fails++; $display("FAIL zero_r0_before_edge: got %h want %h", rdata_z, {32'h55, 32'h0, 32'h0});
    end
    tests++;
    if (rdata_b !== {32'h55, 32'h1234, 32'h1234}) begin
      fails++; $display("FAIL r0_normal_bypass: got %h want %h", rdata_b, {32'h55, 32'h1234, 32'h1234});
    end
    step();
    we = 1'b0;
    #1;
    tests++;
    if (rdata_z !== {32'h55, 32'h0, 32'h0}) begin
      fails++; $display("FAIL zero_r0_after_edge: got %h want %h", rdata_z, {32'h55, 32'h0, 32'h0});
    end
    tests++;
    if (rdata_n !== {32'h55, 32'h1234, 32'h1234}) begin
      fails++; $display("FAIL r0_normal_stored: got %h want %h", rdata_n, {32'h55, 32'h1234, 32'h1234});
    end
  endtask

  task automatic test_async_reset();
    pc_ld = 1'b1; pc_in = 32'h999; we = 1'b1; waddr = 4'd15; wdata = 32'h5;
    step();
    pc_ld = 1'b0; waddr = 4'd2; wdata = 32'h77; pc_en = 1'b1;
    raddr = {4'd5, 4'd1, 4'd15};
    #1;
    tests++;
    if (rdata_b !== {32'hDEAD_BEEF, 32'h55, 32'h999} || clash_b !== 1'b1) begin
      fails++; $display("FAIL preload: got %h clash=%b want %h/1", rdata_b, clash_b, {32'hDEAD_BEEF, 32'h55, 32'h999});
    end
    #1;
    clr = 1'b0;
    #1;
    tests++;
    if (rdata_b !== 96'h0 || rdata_n !== 96'h0 || pc_b !== 32'h0 || clash_b !== 1'b0) begin
      fails++; $display("FAIL async_clear: got %h/%h pc=%h clash=%b want all 0", rdata_b, rdata_n, pc_b, clash_b);
    end
    we = 1'b0;
    #1;
    clr = 1'b1;
    step();
    pc_en = 1'b0;
    tests++;
    if (pc_b !== 32'h4 || rdata_b !== {32'h0, 32'h0, 32'h4}) begin
      fails++; $display("FAIL after_async_release: got pc=%h rdata=%h want 4/%h", pc_b, rdata_b, {32'h0, 32'h0, 32'h4});
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_write_read();
    test_pc_count();
    test_priority();
    test_zero_r0();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
